registros_lectura: RTL and testbench

//  Read-side companion of the 8088 register file: turns two register specifiers (reg field + W bit) into two 16-bit operands.

---
 rtl/regs8088_pkg.sv | 48 ++++
 rtl/reg_operand_sel.sv | 79 +++++++
 rtl/registros_lectura.sv | 97 +++++++++
 tb/tb_registros_lectura.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/regs8088_pkg.sv
// Shared 8088 register-file encodings: reg-field codes, write-enable bit positions, helpers.
package regs8088_pkg;

  localparam int WE_W = 12;

  // W=0 byte register fields
  localparam logic [2:0] REG_AL = 3'd0;
  localparam logic [2:0] REG_CL = 3'd1;
  localparam logic [2:0] REG_DL = 3'd2;
  localparam logic [2:0] REG_BL = 3'd3;
  localparam logic [2:0] REG_AH = 3'd4;
  localparam logic [2:0] REG_CH = 3'd5;
  localparam logic [2:0] REG_DH = 3'd6;
  localparam logic [2:0] REG_BH = 3'd7;

  // W=1 word register fields
  localparam logic [2:0] REG_AX = 3'd0;
  localparam logic [2:0] REG_CX = 3'd1;
  localparam logic [2:0] REG_DX = 3'd2;
  localparam logic [2:0] REG_BX = 3'd3;
  localparam logic [2:0] REG_SP = 3'd4;
  localparam logic [2:0] REG_BP = 3'd5;
  localparam logic [2:0] REG_SI = 3'd6;
  localparam logic [2:0] REG_DI = 3'd7;

  localparam int WE_AL = 11;
  localparam int WE_CL = 10;
  localparam int WE_DL = 9;
  localparam int WE_BL = 8;
  localparam int WE_AH = 7;
  localparam int WE_CH = 6;
  localparam int WE_DH = 5;
  localparam int WE_BH = 4;
  localparam int WE_SP = 3;
  localparam int WE_BP = 2;
  localparam int WE_SI = 1;
  localparam int WE_DI = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rd_state_e;

  function automatic logic [15:0] ext8(input logic [7:0] b, input logic sx);
    return {{8{sx & b[7]}}, b};
  endfunction

endpackage

// File: rtl/reg_operand_sel.sv
// One operand: reg-field decode, same-cycle write bypass, 8->16 extension.
// Purely combinational; no handshake of its own.
module reg_operand_sel
  import regs8088_pkg::*;
#(
  parameter int BYPASS_EN = 1
) (
  input  logic [7:0]      al,
  input  logic [7:0]      cl,
  input  logic [7:0]      dl,
  input  logic [7:0]      bl,
  input  logic [7:0]      ah,
  input  logic [7:0]      ch,
  input  logic [7:0]      dh,
  input  logic [7:0]      bh,
  input  logic [15:0]     sp,
  input  logic [15:0]     bp,
  input  logic [15:0]     si,
  input  logic [15:0]     di,
  input  logic [15:0]     data,
  input  logic [WE_W-1:0] we,
  input  logic            w,
  input  logic [2:0]      rsel,
  input  logic            sx,
  output logic [15:0]     op
);

  localparam bit BYP = (BYPASS_EN != 0);

  logic [7:0]  al_e, cl_e, dl_e, bl_e, ah_e, ch_e, dh_e, bh_e;
  logic [15:0] sp_e, bp_e, si_e, di_e;
  logic [7:0]  byte_val;

  // AX..DX get per-byte merging for free because they are rebuilt from the bypassed halves.
  always_comb begin
    al_e = (BYP && we[WE_AL]) ? data[7:0] : al;
    cl_e = (BYP && we[WE_CL]) ? data[7:0] : cl;
    dl_e = (BYP && we[WE_DL]) ? data[7:0] : dl;
    bl_e = (BYP && we[WE_BL]) ? data[7:0] : bl;
    ah_e = (BYP && we[WE_AH]) ? data[7:0] : ah;
    ch_e = (BYP && we[WE_CH]) ? data[7:0] : ch;
    dh_e = (BYP && we[WE_DH]) ? data[7:0] : dh;
    bh_e = (BYP && we[WE_BH]) ? data[7:0] : bh;
    sp_e = (BYP && we[WE_SP]) ? data : sp;
    bp_e = (BYP && we[WE_BP]) ? data : bp;
    si_e = (BYP && we[WE_SI]) ? data : si;
    di_e = (BYP && we[WE_DI]) ? data : di;

    byte_val = 8'h00;
    op       = 16'h0000;
    if (!w) begin
      case (rsel)
        REG_AL:  byte_val = al_e;
        REG_CL:  byte_val = cl_e;
        REG_DL:  byte_val = dl_e;
        REG_BL:  byte_val = bl_e;
        REG_AH:  byte_val = ah_e;
        REG_CH:  byte_val = ch_e;
        REG_DH:  byte_val = dh_e;
        REG_BH:  byte_val = bh_e;
        default: byte_val = 8'h00;
      endcase
      op = ext8(byte_val, sx);
    end else begin
      case (rsel)
        REG_AX:  op = {ah_e, al_e};
        REG_CX:  op = {ch_e, cl_e};
        REG_DX:  op = {dh_e, dl_e};
        REG_BX:  op = {bh_e, bl_e};
        REG_SP:  op = sp_e;
        REG_BP:  op = bp_e;
        REG_SI:  op = si_e;
        REG_DI:  op = di_e;
        default: op = 16'h0000;
      endcase
    end
  end

endmodule

// File: rtl/registros_lectura.sv
// Register-file read port: two operands captured behind a one-deep valid/ready stage.
// Latency 1 cycle; REQ_READY drops while a response is held and RSP_READY is low.
module registros_lectura
  import regs8088_pkg::*;
#(
  parameter int          BYPASS_EN = 1,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [7:0]      AL,
  input  logic [7:0]      CL,
  input  logic [7:0]      DL,
  input  logic [7:0]      BL,
  input  logic [7:0]      AH,
  input  logic [7:0]      CH,
  input  logic [7:0]      DH,
  input  logic [7:0]      BH,
  input  logic [15:0]     SP,
  input  logic [15:0]     BP,
  input  logic [15:0]     SI,
  input  logic [15:0]     DI,
  input  logic [15:0]     DATA,
  input  logic [WE_W-1:0] WE,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic            REQ_W,
  input  logic [2:0]      REQ_RA,
  input  logic [2:0]      REQ_RB,
  input  logic            REQ_SX,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [15:0]     OPA,
  output logic [15:0]     OPB
);

  rd_state_e   state_q, state_d;
  logic [15:0] opa_q, opa_d, opb_q, opb_d;
  logic [15:0] sel_a, sel_b;
  logic        accept;

  reg_operand_sel #(.BYPASS_EN(BYPASS_EN)) u_sel_a (
    .al(AL), .cl(CL), .dl(DL), .bl(BL), .ah(AH), .ch(CH), .dh(DH), .bh(BH),
    .sp(SP), .bp(BP), .si(SI), .di(DI), .data(DATA), .we(WE),
    .w(REQ_W), .rsel(REQ_RA), .sx(REQ_SX), .op(sel_a)
  );

  reg_operand_sel #(.BYPASS_EN(BYPASS_EN)) u_sel_b (
    .al(AL), .cl(CL), .dl(DL), .bl(BL), .ah(AH), .ch(CH), .dh(DH), .bh(BH),
    .sp(SP), .bp(BP), .si(SI), .di(DI), .data(DATA), .we(WE),
    .w(REQ_W), .rsel(REQ_RB), .sx(REQ_SX), .op(sel_b)
  );

  assign RSP_VALID = (state_q == ST_FULL);
  assign REQ_READY = !RST && (!RSP_VALID || RSP_READY);
  assign accept    = REQ_VALID && REQ_READY;
  assign OPA       = opa_q;
  assign OPB       = opb_q;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
          opa_d   = sel_a;
          opb_d   = sel_b;
        end
      end
      ST_FULL: begin
        // Operands are frozen until the consumer takes them; writes meanwhile are not seen.
        if (accept) begin
          opa_d = sel_a;
          opb_d = sel_b;
        end else if (RSP_READY) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      opa_q   <= RESET_VAL;
      opb_q   <= RESET_VAL;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

endmodule

// File: tb/tb_registros_lectura.sv
// Bench for registros_lectura: directed cases then random traffic against a register-file model,
// covering both bypass settings with two instances driven from the same inputs.
module tb_registros_lectura;

  localparam logic [15:0] RV_NB = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rb8 [8];   // AL,CL,DL,BL,AH,CH,DH,BH
  logic [15:0] rw  [4];   // SP,BP,SI,DI
  logic [15:0] data;
  logic [11:0] we;
  logic        req_valid, req_w, req_sx, rsp_ready;
  logic [2:0]  req_ra, req_rb;

  logic        req_ready, rsp_valid, req_ready_nb, rsp_valid_nb;
  logic [15:0] opa, opb, opa_nb, opb_nb;

  int tests = 0;
  int fails = 0;

  logic        exp_v;
  logic        exp_ops_def;
  logic [15:0] exp_a, exp_b, exp_a_nb, exp_b_nb;

  always #5 clk = ~clk;

  registros_lectura #(.BYPASS_EN(1), .RESET_VAL(16'h0000)) dut (
    .CLK(clk), .RST(rst),
    .AL(rb8[0]), .CL(rb8[1]), .DL(rb8[2]), .BL(rb8[3]),
    .AH(rb8[4]), .CH(rb8[5]), .DH(rb8[6]), .BH(rb8[7]),
    .SP(rw[0]), .BP(rw[1]), .SI(rw[2]), .DI(rw[3]),
    .DATA(data), .WE(we),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_W(req_w),
    .REQ_RA(req_ra), .REQ_RB(req_rb), .REQ_SX(req_sx),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .OPA(opa), .OPB(opb)
  );

  registros_lectura #(.BYPASS_EN(0), .RESET_VAL(RV_NB)) dut_nb (
    .CLK(clk), .RST(rst),
    .AL(rb8[0]), .CL(rb8[1]), .DL(rb8[2]), .BL(rb8[3]),
    .AH(rb8[4]), .CH(rb8[5]), .DH(rb8[6]), .BH(rb8[7]),
    .SP(rw[0]), .BP(rw[1]), .SI(rw[2]), .DI(rw[3]),
    .DATA(data), .WE(we),
    .REQ_VALID(req_valid), .REQ_READY(req_ready_nb), .REQ_W(req_w),
    .REQ_RA(req_ra), .REQ_RB(req_rb), .REQ_SX(req_sx),
    .RSP_VALID(rsp_valid_nb), .RSP_READY(rsp_ready), .OPA(opa_nb), .OPB(opb_nb)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Register file as seen by a reader this cycle: a write with its enable set wins when bypassing.
  function automatic logic [15:0] ref_read(input logic byp, input logic [2:0] r);
    logic [7:0]  b [8];
    logic [15:0] wd [4];
    for (int i = 0; i < 8; i++) b[i]  = (byp && we[11 - i]) ? data[7:0] : rb8[i];
    for (int i = 0; i < 4; i++) wd[i] = (byp && we[3 - i])  ? data      : rw[i];
    if (!req_w) return {{8{req_sx & b[r][7]}}, b[r]};
    if (r < 4)  return {b[r + 4], b[r]};
    return wd[r - 4];
  endfunction

  task automatic tick();
    logic exp_rdy;
    #1;
    exp_rdy = !rst && (!exp_v || rsp_ready);
    chk("req_ready", {15'd0, req_ready}, {15'd0, exp_rdy});
    chk("req_ready_nb", {15'd0, req_ready_nb}, {15'd0, exp_rdy});
    if (rst) begin
      exp_v = 1'b0; exp_ops_def = 1'b1;
      exp_a = 16'h0000; exp_b = 16'h0000; exp_a_nb = RV_NB; exp_b_nb = RV_NB;
    end else if (req_valid && exp_rdy) begin
      exp_v = 1'b1; exp_ops_def = 1'b1;
      exp_a = ref_read(1'b1, req_ra); exp_b = ref_read(1'b1, req_rb);
      exp_a_nb = ref_read(1'b0, req_ra); exp_b_nb = ref_read(1'b0, req_rb);
    end else if (exp_v && rsp_ready) begin
      exp_v = 1'b0; exp_ops_def = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", {15'd0, rsp_valid}, {15'd0, exp_v});
    chk("rsp_valid_nb", {15'd0, rsp_valid_nb}, {15'd0, exp_v});
    if (exp_ops_def) begin
      chk("opa", opa, exp_a);
      chk("opb", opb, exp_b);
      chk("opa_nb", opa_nb, exp_a_nb);
      chk("opb_nb", opb_nb, exp_b_nb);
    end
  endtask

  initial begin
    exp_v = 1'b0; exp_ops_def = 1'b0;
    exp_a = '0; exp_b = '0; exp_a_nb = '0; exp_b_nb = '0;
    for (int i = 0; i < 8; i++) rb8[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) rw[i] = 16'($urandom);
    data = 16'h0000; we = 12'h000;
    req_w = 1'b1; req_ra = 3'd0; req_rb = 3'd1; req_sx = 1'b0; rsp_ready = 1'b1;

    // Reset with a request pending: must be dropped
    rst = 1'b1; req_valid = 1'b1;
    tick();
    tick();
    chk("reset_opa", opa, 16'h0000);
    chk("reset_opb", opb, 16'h0000);
    chk("reset_opa_nb", opa_nb, RV_NB);
    chk("reset_valid", {15'd0, rsp_valid}, 16'h0000);

    // Word read AX / SI
    rst = 1'b0;
    rb8[4] = 8'h12; rb8[0] = 8'h34; rw[2] = 16'hBEEF;
    req_w = 1'b1; req_ra = 3'd0; req_rb = 3'd6;
    tick();
    chk("word_opa", opa, 16'h1234);
    chk("word_opb", opb, 16'hBEEF);
    chk("word_valid", {15'd0, rsp_valid}, 16'h0001);

    // Byte BH with sign / zero extension, RA==RB
    rb8[7] = 8'hF0; req_w = 1'b0; req_ra = 3'd7; req_rb = 3'd7; req_sx = 1'b1;
    tick();
    chk("sx_opa", opa, 16'hFFF0);
    chk("sx_opb", opb, 16'hFFF0);
    req_sx = 1'b0;
    tick();
    chk("zx_opa", opa, 16'h00F0);

    // Same-cycle AL write during AX read
    rb8[0] = 8'h34; rb8[4] = 8'h12; we = 12'h800; data = 16'h00AA;
    req_w = 1'b1; req_ra = 3'd0; req_rb = 3'd4;
    tick();
    chk("bypass_opa", opa, 16'h12AA);
    chk("nobypass_opa", opa_nb, 16'h1234);
    we = 12'h000;

    // Stall while SI is being written: captured operands stay frozen
    rw[2] = 16'h1111; req_ra = 3'd6; req_rb = 3'd0;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data = 16'($urandom); we = 12'h002; rw[2] = data; req_ra = 3'($urandom);
      tick();
      chk("stall_opa", opa, 16'h1111);
      chk("stall_ready", {15'd0, req_ready}, 16'h0000);
    end
    we = 12'h000; rw[2] = 16'h2222; req_ra = 3'd6; rsp_ready = 1'b1;
    tick();
    chk("post_stall_opa", opa, 16'h2222);
    chk("post_stall_valid", {15'd0, rsp_valid}, 16'h0001);

    // Reset while stalled discards the held response
    rsp_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("midreset_valid", {15'd0, rsp_valid}, 16'h0000);
    chk("midreset_opa", opa, 16'h0000);
    chk("midreset_opb_nb", opb_nb, RV_NB);
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      req_w     = 1'($urandom);
      req_sx    = 1'($urandom);
      req_ra    = 3'($urandom);
      req_rb    = 3'($urandom);
      data      = 16'($urandom);
      we        = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom);
      if ($urandom_range(0, 1) == 0) rb8[$urandom_range(0, 7)] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) rw[$urandom_range(0, 3)] = 16'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
